// File: rtl/and4_operand_fifo.sv
// ---------------------------------------------------------------------------
// and4_operand_fifo
//
// Operand-staging FIFO in front of the 4-bit AND datapath unit. Producer pairs
// {a, b} are accepted over a valid/ready handshake, held in order, and the
// oldest pair is presented on out_a/out_b to drive the AND unit directly.
// The consumer pops the head by asserting out_ready once it has sampled the
// AND result.
//
// Parameters
//   WIDTH      operand width (matches the AND unit)
//   DEPTH      number of stored pairs, power of two, >= 2
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   producer presents a pair on in_a/in_b
//   in_ready   FIFO can accept a pair this cycle (state-only, never from in_valid)
//   in_a/in_b  producer operands
//   out_valid  out_a/out_b hold the head pair
//   out_ready  consumer done with head; pops it
//   out_a/b    head operands (zero when empty)
//   count      occupancy 0..DEPTH           (AND_FIFO_STATUS_EN only)
//   ovf        sticky push-while-full flag  (AND_FIFO_STATUS_EN only)
//
// Build option
//   AND_FIFO_STATUS_EN  adds the count/ovf status ports and their logic.
//                       The data path is identical either way.
// ---------------------------------------------------------------------------
module and4_operand_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_a,
    output logic [WIDTH-1:0]         out_b
`ifdef AND_FIFO_STATUS_EN
    ,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
`endif
);

    localparam int AW = $clog2(DEPTH);   // index bits
    localparam int PW = AW + 1;          // pointer bits, MSB is the wrap bit

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } pair_t;

    pair_t           mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx;
    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    pair_t           head;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];

    // Same index with opposite wrap bits means the writer is a full lap ahead.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);

    assign in_ready  = !full;
    assign out_valid = !empty;

    // When full, in_ready is low, so a same-cycle pop never lets a push
    // through; the slot frees up for the following cycle.
    assign push = in_valid && !full;
    assign pop  = out_ready && !empty;

    // Storage is not reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= '{a: in_a, b: in_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Head is gated so the AND unit sees zeros rather than stale storage
    // while empty (including straight out of reset).
    always_comb begin
        head = '0;
        if (!empty) head = mem[rd_idx];
    end

    assign out_a = head.a;
    assign out_b = head.b;

`ifdef AND_FIFO_STATUS_EN
    // Pointer difference modulo 2*DEPTH gives occupancy 0..DEPTH directly.
    assign count = wr_ptr - rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (in_valid && full) begin
            ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_and4_operand_fifo.sv
module tb_and4_operand_fifo;
    localparam int W = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a, in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_a, out_b;
`ifdef AND_FIFO_STATUS_EN
    logic [$clog2(D):0] count;
    logic               ovf;
`endif

    and4_operand_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b)
`ifdef AND_FIFO_STATUS_EN
        ,
        .count     (count),
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: an ordered queue of pairs plus a sticky overflow bit.
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } pair_t;
    pair_t q[$];
    bit    m_ovf;

    function automatic logic [W-1:0] m_a();
        return (q.size() > 0) ? q[0].a : '0;
    endfunction
    function automatic logic [W-1:0] m_b();
        return (q.size() > 0) ? q[0].b : '0;
    endfunction

    // Drive one cycle of inputs, advance past the rising edge, update the model.
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic r);
        bit do_push, do_pop;
        pair_t p;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        out_ready = r;
        do_push = v && (q.size() < D);
        do_pop  = r && (q.size() > 0);
        if (v && q.size() == D) m_ovf = 1'b1;
        @(posedge clk);
        #1;
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
            p.a = a;
            p.b = b;
            q.push_back(p);
        end
    endtask

    task automatic hard_reset();
        rst_n = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_valid = 0; in_a = 0; in_b = 0; out_ready = 0;
        hard_reset();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_a !== '0 || out_b !== '0) begin
            errors++;
            $display("FAIL reset_init: out_valid=%b in_ready=%b out_a=%0d out_b=%0d, want 0 1 0 0",
                     out_valid, in_ready, out_a, out_b);
        end
        // Mid-stream reset with two pairs stored.
        step(1, 4'd3, 4'd7, 0);
        step(1, 4'd5, 4'd6, 0);
        step(0, 4'd0, 4'd0, 0);
        checks++;
        if (out_valid !== 1'b1 || out_a !== 4'd3) begin
            errors++;
            $display("FAIL reset_prefill: out_valid=%b out_a=%0d, want 1 3", out_valid, out_a);
        end
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        m_ovf = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_a !== '0 || out_b !== '0) begin
            errors++;
            $display("FAIL reset_async: out_valid=%b in_ready=%b out_a=%0d out_b=%0d, want 0 1 0 0",
                     out_valid, in_ready, out_a, out_b);
        end
`ifdef AND_FIFO_STATUS_EN
        checks++;
        if (count !== '0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: count=%0d ovf=%b, want 0 0", count, ovf);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 4'd0, 4'd0, 1);
            checks++;
            if (out_valid !== 1'b0 || out_a !== '0) begin
                errors++;
                $display("FAIL reset_stale: out_valid=%b out_a=%0d, want 0 0", out_valid, out_a);
            end
        end
    endtask

    task automatic test_single();
        step(1, 4'b1010, 4'b1111, 0);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_a !== 4'd10 || out_b !== 4'd15 || (out_a & out_b) !== 4'd10) begin
                errors++;
                $display("FAIL single_hold[%0d]: out_valid=%b a=%0d b=%0d, want 1 10 15",
                         i, out_valid, out_a, out_b);
            end
            if (i < 5) step(0, 4'd0, 4'd0, 0);
        end
        step(0, 4'd0, 4'd0, 1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pop: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_fill_full();
        for (int i = 1; i <= 4; i++) step(1, 4'(i), 4'd15, 0);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_ready: in_ready=%b, want 0", in_ready);
        end
`ifdef AND_FIFO_STATUS_EN
        checks++;
        if (count !== 3'(D)) begin
            errors++;
            $display("FAIL fill_count: count=%0d, want %0d", count, D);
        end
`endif
        step(1, 4'd9, 4'd9, 0);
`ifdef AND_FIFO_STATUS_EN
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL fill_ovf: ovf=%b, want 1", ovf);
        end
`endif
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_a !== 4'(i) || out_b !== 4'd15) begin
                errors++;
                $display("FAIL fill_drain[%0d]: valid=%b a=%0d b=%0d, want 1 %0d 15",
                         i, out_valid, out_a, out_b, i);
            end
            step(0, 4'd0, 4'd0, 1);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fill_extra: out_valid=%b a=%0d, want empty", out_valid, out_a);
        end
    endtask

    task automatic test_full_pop();
        for (int i = 1; i <= 4; i++) step(1, 4'(i), 4'd7, 0);
        step(1, 4'd5, 4'd5, 1);   // pop only; full blocks the push
        checks++;
        if (in_ready !== 1'b1 || out_a !== 4'd2 || q.size() != 3) begin
            errors++;
            $display("FAIL fullpop_nopush: in_ready=%b a=%0d, want 1 2", in_ready, out_a);
        end
        step(1, 4'd5, 4'd5, 0);   // accepted now
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fullpop_accept: in_ready=%b, want 0", in_ready);
        end
`ifdef AND_FIFO_STATUS_EN
        checks++;
        if (count !== 3'(D)) begin
            errors++;
            $display("FAIL fullpop_count: count=%0d, want %0d", count, D);
        end
`endif
        while (q.size() > 0) begin
            checks++;
            if (out_a !== m_a() || out_b !== m_b()) begin
                errors++;
                $display("FAIL fullpop_drain: a=%0d b=%0d, want %0d %0d", out_a, out_b, m_a(), m_b());
            end
            step(0, 4'd0, 4'd0, 1);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fullpop_empty: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 16; i++) begin
            step(1, 4'(i), 4'b0110, 1);
            checks++;
            if (out_valid !== 1'b1 || out_a !== 4'(i) || (out_a & out_b) !== (4'(i) & 4'b0110)) begin
                errors++;
                $display("FAIL stream[%0d]: valid=%b y=%0d, want 1 %0d",
                         i, out_valid, out_a & out_b, 4'(i) & 4'b0110);
            end
`ifdef AND_FIFO_STATUS_EN
            checks++;
            if (count !== 3'd1) begin
                errors++;
                $display("FAIL stream_count[%0d]: count=%0d, want 1", i, count);
            end
`endif
        end
        step(0, 4'd0, 4'd0, 1);
    endtask

    task automatic test_wrap();
        localparam int N = 3 * D + 1;
        logic [2*W-1:0] sent_q[$];
        int sent = 0;
        int recv = 0;
        int cyc  = 0;
        logic [W-1:0] ra, rb;
        logic v, r;
        hard_reset();
        while (recv < N && cyc < 500) begin
            v  = (sent < N) && in_ready && ($urandom_range(0, 3) != 0);
            r  = $urandom_range(0, 1) == 1;
            ra = 4'($urandom);
            rb = 4'($urandom);
            if (out_valid && r) begin
                checks++;
                if ({out_a, out_b} !== sent_q[recv]) begin
                    errors++;
                    $display("FAIL wrap_order[%0d]: got %h, want %h", recv, {out_a, out_b}, sent_q[recv]);
                end
                recv++;
            end
            if (v) begin
                sent_q.push_back({ra, rb});
                sent++;
            end
            step(v, ra, rb, r);
            cyc++;
            checks++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < D) ||
                out_a !== m_a() || out_b !== m_b()) begin
                errors++;
                $display("FAIL wrap_state[%0d]: valid=%b ready=%b a=%0d b=%0d, want %b %b %0d %0d",
                         cyc, out_valid, in_ready, out_a, out_b,
                         q.size() > 0, q.size() < D, m_a(), m_b());
            end
        end
        checks++;
        if (recv != N) begin
            errors++;
            $display("FAIL wrap_timeout: received %0d, want %0d", recv, N);
        end
`ifdef AND_FIFO_STATUS_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL wrap_ovf: ovf=%b, want 0", ovf);
        end
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        m_ovf = 1'b0;
        test_reset();
        test_single();
        test_fill_full();
        test_full_pop();
        test_stream();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/and4_operand_fifo.md
# and4_operand_fifo

Operand-staging buffer that sits directly upstream of the 4-bit AND datapath unit. It accepts operand pairs {a, b} from a producer over a valid/ready handshake and stores up to DEPTH pairs in order. It presents the oldest pair on out_a/out_b, which drive the AND unit's a/b inputs. Back-pressure from the consumer, which samples the AND result, pops pairs one at a time.

## Interface
- WIDTH, 4, operand width in bits (matches AND unit width).
- DEPTH, 4, number of stored pairs; power of two, ≥ 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer has a pair on in_a/in_b.
- in_ready  out  1  FIFO can accept a pair this cycle.
- in_a  in  WIDTH  operand a from producer.
- in_b  in  WIDTH  operand b from producer.
- out_valid  out  1  out_a/out_b hold a valid pair.
- out_ready  in  1  consumer has sampled the AND result; pop the head.
- out_a  out  WIDTH  head operand a, to AND unit a.
- out_b  out  WIDTH  head operand b, to AND unit b.
- count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH. Present only with AND_FIFO_STATUS_EN.
- ovf  out  1  sticky overflow flag. Present only with AND_FIFO_STATUS_EN.

## Operation
- Storage: DEPTH × 2·WIDTH register array. Write/read pointers are $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
- empty = (wr_ptr == rd_ptr). full = index bits equal and wrap bits differ.
- in_ready = !full (combinational from state only; never from in_valid).
- Push: in_valid && in_ready at a rising edge writes {in_a, in_b} to mem[wr_ptr index] and increments wr_ptr.
- out_valid = !empty.
- out_a/out_b = mem[rd_ptr index] when !empty, else 0.
- Pop: out_valid && out_ready at a rising edge increments rd_ptr.
- Pointers wrap modulo 2·DEPTH naturally; index wraps modulo DEPTH.
- Simultaneous push and pop (neither full nor empty): both occur; occupancy unchanged.
- Full: in_ready = 0, so no push, even if a pop happens the same cycle (no pass-through). in_ready rises the cycle after the pop.
- Empty: out_valid = 0, so no pop; out_ready is ignored. No bypass: a pushed pair is never visible in the same cycle.
- Pairs pop in push order; no reordering, no drop.
- Producer must hold in_a/in_b/in_valid until accepted. The FIFO holds out_a/out_b stable while out_valid && !out_ready.

## Timing
- Reset (async assert, sync release by external synchronizer):
  - pointers = 0, in_ready = 1, out_valid = 0, out_a = out_b = 0.
  - count = 0, ovf = 0.
  - mem contents are not reset.
- Latency: pair pushed at edge N → out_valid = 1 and data on out_a/out_b after edge N. AND result is valid combinationally in the same cycle.
- Throughput: one push and one pop per cycle sustained.
- Reset mid-operation: all stored pairs discarded immediately; outputs take reset values asynchronously.

## Configuration
- Macro AND_FIFO_STATUS_EN.
- Defined:
  - count port = wr_ptr − rd_ptr (registered pointers, combinational subtract).
  - ovf port set on any edge where in_valid && full; cleared only by rst_n.
- Undefined:
  - count and ovf ports and their logic do not exist.
  - Data path behaviour is identical.

## Test plan
- Reset: assert rst_n = 0 mid-stream with 2 pairs stored → out_valid = 0, in_ready = 1, out_a = out_b = 0, count = 0 immediately; after release, no stale pairs appear.
- Single pair: push a = 4'b1010, b = 4'b1111 with out_ready = 0 → next cycle out_valid = 1, out_a = 10, out_b = 15, AND y = 10; held 5 cycles; pulse out_ready → out_valid = 0 next cycle.
- Fill/full: push 4 pairs (1,15), (2,15), (3,15), (4,15) with out_ready = 0 → in_ready = 0 after the 4th, count = 4. Extra in_valid with (9,9) is not stored, ovf = 1. Drain → pops 1, 2, 3, 4 in order; (9,9) never appears.
- Full + pop same cycle: when full, hold in_valid with (5,5) and assert out_ready → pop occurs, no push that cycle; (5,5) accepted the following cycle, count = 4.
- Streaming: in_valid = out_ready = 1 continuously with a = 0..15, b = 4'b0110 → one pair per cycle, y = a & 6 in order, count stays 1, no gaps after the first cycle.
- Wrap-around: 3·DEPTH+1 pushes interleaved with random out_ready → all pairs delivered in order; pointer wrap causes no false full/empty; ovf stays 0.
